// File: rtl/display_scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// display_scan_mux_pkg
//   Shared types and helpers for the multiplexed 7-segment status display.
//   - state_e    : scan FSM states (IDLE, BLANK, DRIVE)
//   - SEG_OFF    : all segments dark (active-low)
//   - hex_to_seg : hex nibble to active-low {g,f,e,d,c,b,a} pattern
// ---------------------------------------------------------------------------
package display_scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_mux_edge_sync.sv
// ---------------------------------------------------------------------------
// display_scan_mux_edge_sync
//   Brings a slow divider output into the clk domain through a SYNC_STAGES
//   flop chain and derives a one-clk rising-edge pulse from it.
//   Ports:
//     clk    in  system clock
//     reset  in  asynchronous, active-low reset (chain cleared to 0)
//     din    in  asynchronous level from the clock divider
//     level  out synchronised level
//     pulse  out one-cycle pulse on each synchronised rising edge
// ---------------------------------------------------------------------------
module display_scan_mux_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], din};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level = chain_q[SYNC_STAGES-1];
    assign pulse = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed 7-segment driver. The divider outputs are treated as
//   data: scan_div rising edges step through the digits, blink_div's level
//   gates digits selected in blink_mask. Every digit change is preceded by
//   one all-dark BLANK cycle to suppress ghosting.
//   Ports:
//     clk         in  system clock (only clock)
//     reset       in  asynchronous, active-low reset
//     scan_div    in  scan-rate square wave (one step per rising edge)
//     blink_div   in  blink-rate square wave (level = blink phase)
//     enable      in  1 = display on, 0 = dark and parked in IDLE
//     digit_data  in  hex nibble per digit, digit i = [4i+3:4i]
//     dp_in       in  decimal point per digit, 1 = lit
//     blink_mask  in  1 = digit i blinks
//     seg_n       out segments {g,f,e,d,c,b,a}, active-low, registered
//     dp_n        out decimal point, active-low, registered
//     an_n        out anodes, active-low one-cold, registered
//     digit_idx   out currently selected digit, registered
// ---------------------------------------------------------------------------
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_div,
    input  logic                  blink_div,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digit_data,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic [IDX_W-1:0]      digit_idx
);

    logic scan_pulse;
    logic scan_level_unused;
    logic blink_phase;
    logic blink_pulse_unused;

    display_scan_mux_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scan_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scan_div),
        .level (scan_level_unused),
        .pulse (scan_pulse)
    );

    display_scan_mux_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_blink_sync (
        .clk   (clk),
        .reset (reset),
        .din   (blink_div),
        .level (blink_phase),
        .pulse (blink_pulse_unused)
    );

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           snap_q, snap_d;
    logic                 snap_dp_q, snap_dp_d;
    logic [6:0]           seg_n_q, seg_n_d;
    logic                 dp_n_q, dp_n_d;
    logic [N_DIGITS-1:0]  an_n_q, an_n_d;

    // Next-state. The snapshot is taken on the BLANK->DRIVE transition so the
    // shown digit stays stable for the whole DRIVE period. A scan pulse that
    // lands in BLANK is simply not looked at.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_pulse) state_d = BLANK;
                end
                BLANK: begin
                    state_d   = DRIVE;
                    snap_d    = digit_data[{idx_q, 2'b00} +: 4];
                    snap_dp_d = dp_in[idx_q];
                end
                DRIVE: begin
                    if (scan_pulse) begin
                        state_d = BLANK;
                        idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so the registered pins line up
    // with the state register: dark in BLANK, new digit on the first DRIVE edge.
    // Blink gating uses the live mask and phase, not the snapshot.
    always_comb begin
        seg_n_d = SEG_OFF;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        if (state_d == DRIVE) begin
            seg_n_d = hex_to_seg(snap_d);
            dp_n_d  = ~snap_dp_d;
            if (!(blink_mask[idx_d] & ~blink_phase)) begin
                an_n_d = ~(N_DIGITS'(1) << idx_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seg_n_q <= SEG_OFF;
            dp_n_q  <= 1'b1;
            an_n_q  <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_n_q <= seg_n_d;
            dp_n_q  <= dp_n_d;
            an_n_q  <= an_n_d;
        end
    end

    // The snapshot is pure data and only ever read in DRIVE, which is always
    // entered through BLANK where it is loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        snap_q    <= snap_d;
        snap_dp_q <= snap_dp_d;
    end

    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;
    assign an_n      = an_n_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

    logic        clk;
    logic        reset;
    logic        scan_div;
    logic        blink_div;
    logic        enable;
    logic [15:0] digit_data;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;

    int checks   = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    logic [13:0] prev_tuple;
    logic        mon_en = 1'b0;

    display_scan_mux #(.N_DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_div   (scan_div),
        .blink_div  (blink_div),
        .enable     (enable),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .digit_idx  (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic [3:0] an, input logic [6:0] seg,
                                       input logic dp, input logic [1:0] idx);
        return {an, seg, dp, idx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every change of the output tuple is one DUT event.
    always @(negedge clk) begin
        logic [13:0] cur;
        logic [13:0] exp;
        if (mon_en) begin
            cur = {an_n, seg_n, dp_n, digit_idx};
            if (cur !== prev_tuple) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected got=%h required=no_change (t=%0t)", cur, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_out", 32'(cur), 32'(exp));
                end
                prev_tuple = cur;
            end
        end
    end

    // One scan_div rising edge with cycle-exact checks of the blank/drive timing.
    task automatic scan_step(input bit push_blank, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp, input logic [1:0] e_idx);
        if (push_blank) exp_q.push_back(mk(4'hF, 7'h7F, 1'b1, e_idx));
        exp_q.push_back(mk(e_an, e_seg, e_dp, e_idx));
        @(negedge clk);
        scan_div = 1'b1;
        @(posedge clk);   // t0
        @(posedge clk);   // t0+1
        @(posedge clk);   // t0+2
        #1;
        check("blank_an", 32'(an_n), 32'(4'hF));
        check("blank_idx", 32'(digit_idx), 32'(e_idx));
        @(posedge clk);   // t0+3
        #1;
        check("drive_an", 32'(an_n), 32'(e_an));
        check("drive_seg", 32'(seg_n), 32'(e_seg));
        @(negedge clk);
        scan_div = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic toggle_scan();
        @(negedge clk);
        scan_div = 1'b1;
        repeat (3) @(negedge clk);
        scan_div = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        scan_div   = 1'b0;
        blink_div  = 1'b0;
        enable     = 1'b0;
        digit_data = 16'h0000;
        dp_in      = 4'b0000;
        blink_mask = 4'b0000;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seg_n), 32'(7'h7F));
        check("rst_dp", 32'(dp_n), 32'(1'b1));
        check("rst_an", 32'(an_n), 32'(4'hF));
        check("rst_idx", 32'(digit_idx), 32'(2'd0));
        reset = 1'b1;
        #1;
        prev_tuple = {an_n, seg_n, dp_n, digit_idx};
        mon_en     = 1'b1;

        // Disabled display stays dark while scan_div toggles.
        repeat (3) toggle_scan();
        check("dis_an", 32'(an_n), 32'(4'hF));
        check("dis_seg", 32'(seg_n), 32'(7'h7F));

        // Full scan of 3,2,1,0 then wrap to digit 0.
        @(negedge clk);
        enable     = 1'b1;
        digit_data = 16'h3210;
        blink_div  = 1'b1;
        repeat (4) @(negedge clk);
        scan_step(1'b0, 4'hE, 7'h40, 1'b1, 2'd0);
        scan_step(1'b1, 4'hD, 7'h79, 1'b1, 2'd1);
        scan_step(1'b1, 4'hB, 7'h24, 1'b1, 2'd2);
        scan_step(1'b1, 4'h7, 7'h30, 1'b1, 2'd3);
        scan_step(1'b1, 4'hE, 7'h40, 1'b1, 2'd0);

        // Blinking digit 1: dark in the off phase, lit 3 clks after phase rises.
        blink_mask = 4'b0010;
        blink_div  = 1'b0;
        repeat (4) @(negedge clk);
        scan_step(1'b1, 4'hF, 7'h79, 1'b1, 2'd1);
        exp_q.push_back(mk(4'hD, 7'h79, 1'b1, 2'd1));
        @(negedge clk);
        blink_div = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("blink_early_an", 32'(an_n), 32'(4'hF));
        @(posedge clk);
        #1 check("blink_on_an", 32'(an_n), 32'(4'hD));

        // Data changes mid-DRIVE are held off until the next step.
        @(negedge clk);
        digit_data = 16'hDCBA;
        dp_in      = 4'b0001;
        repeat (4) @(negedge clk);
        check("hold_seg", 32'(seg_n), 32'(7'h79));
        check("hold_dp", 32'(dp_n), 32'(1'b1));
        scan_step(1'b1, 4'hB, 7'h46, 1'b1, 2'd2);
        scan_step(1'b1, 4'h7, 7'h21, 1'b1, 2'd3);
        scan_step(1'b1, 4'hE, 7'h08, 1'b0, 2'd0);
        check("dp_lit", 32'(dp_n), 32'(1'b0));
        digit_data = 16'h5E9F;
        repeat (3) @(negedge clk);
        check("hold_seg2", 32'(seg_n), 32'(7'h08));
        scan_step(1'b1, 4'hD, 7'h10, 1'b1, 2'd1);

        // Asynchronous reset mid-DRIVE darkens outputs immediately.
        exp_q.push_back(mk(4'hF, 7'h7F, 1'b1, 2'd0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_an", 32'(an_n), 32'(4'hF));
        check("arst_seg", 32'(seg_n), 32'(7'h7F));
        check("arst_idx", 32'(digit_idx), 32'(2'd0));
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        scan_step(1'b0, 4'hE, 7'h0E, 1'b0, 2'd0);
        scan_step(1'b1, 4'hD, 7'h10, 1'b1, 2'd1);

        // Dropping enable parks in IDLE at the next edge.
        exp_q.push_back(mk(4'hF, 7'h7F, 1'b1, 2'd0));
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_idx", 32'(digit_idx), 32'(2'd0));
        check("dis_an2", 32'(an_n), 32'(4'hF));

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
